fetch_redirect_ctrl: RTL and testbench

//  Sequences the program counter and IF stage: merges redirect sources (trap, EX branch, ID jump),

---
 rtl/fetch_redirect_if.sv | 33 +++
 rtl/fetch_redirect_ctrl.sv | 134 +++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_redirect_if.sv
// Handshake bundle between the fetch redirect controller and the PC / imem / pipeline side.
interface fetch_redirect_if #(
    parameter int unsigned AW = 32
);
    logic          imem_ack;
    logic          hazard_stall;
    logic          trap_req;
    logic [AW-1:0] trap_vec;
    logic          br_taken_ex;
    logic [AW-1:0] br_target_ex;
    logic          jmp_id;
    logic [AW-1:0] jmp_target_id;
    logic          imem_req;
    logic          stall;
    logic          j_br;
    logic [AW-1:0] bta;
    logic          if_valid;
    logic          flush_id;
    logic          flush_ex;
    logic          imem_timeout;

    modport master (
        input  imem_ack, hazard_stall, trap_req, trap_vec, br_taken_ex, br_target_ex,
               jmp_id, jmp_target_id,
        output imem_req, stall, j_br, bta, if_valid, flush_id, flush_ex, imem_timeout
    );

    modport slave (
        output imem_ack, hazard_stall, trap_req, trap_vec, br_taken_ex, br_target_ex,
               jmp_id, jmp_target_id,
        input  imem_req, stall, j_br, bta, if_valid, flush_id, flush_ex, imem_timeout
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// PC / IF sequencer: merges trap, EX-branch and ID-jump redirects and defers them
// while the imem access at PC_IF is still outstanding.
module fetch_redirect_ctrl #(
    parameter int unsigned AW       = 32,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    fetch_redirect_if.master bus
);
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);
    localparam logic [CW-1:0] WAIT_SAT = '1;

    typedef enum logic {RUN, PEND} state_t;

    state_t        state_q, state_d;
    logic [1:0]    pend_cls_q, pend_cls_d;
    logic [AW-1:0] pend_tgt_q, pend_tgt_d;
    logic [CW-1:0] wait_cnt_q;
    logic          timeout_q;
    logic [1:0]    sel_cls;
    logic [AW-1:0] sel_tgt;

    // Redirect priority: trap (3) > EX branch (2) > ID jump (1); 0 = none
    always_comb begin
        sel_cls = 2'd0;
        sel_tgt = '0;
        if (bus.trap_req) begin
            sel_cls = 2'd3;
            sel_tgt = bus.trap_vec;
        end else if (bus.br_taken_ex) begin
            sel_cls = 2'd2;
            sel_tgt = bus.br_target_ex;
        end else if (bus.jmp_id) begin
            sel_cls = 2'd1;
            sel_tgt = bus.jmp_target_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            pend_cls_q <= 2'd0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_cls_q <= pend_cls_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // Wait counter and sticky timeout for the access outstanding at PC_IF
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (bus.imem_ack) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != WAIT_SAT) begin
                wait_cnt_q <= wait_cnt_q + CW'(1);
            end
            if (!bus.imem_ack && (wait_cnt_q >= WAIT_LIM)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        pend_cls_d       = pend_cls_q;
        pend_tgt_d       = pend_tgt_q;
        bus.imem_req     = 1'b1;
        bus.stall        = 1'b0;
        bus.j_br         = 1'b0;
        bus.bta          = '0;
        bus.if_valid     = 1'b0;
        bus.flush_id     = 1'b0;
        bus.flush_ex     = 1'b0;
        bus.imem_timeout = timeout_q;

        case (state_q)
            RUN: begin
                if (sel_cls == 2'd0) begin
                    bus.if_valid = bus.imem_ack & ~bus.hazard_stall;
                    bus.stall    = ~bus.if_valid;
                end else begin
                    bus.flush_id = 1'b1;
                    bus.flush_ex = sel_cls[1];
                    if (bus.imem_ack) begin
                        bus.j_br = 1'b1;
                        bus.bta  = sel_tgt;
                    end else begin
                        bus.stall  = 1'b1;
                        pend_cls_d = sel_cls;
                        pend_tgt_d = sel_tgt;
                        state_d    = PEND;
                    end
                end
            end
            PEND: begin
                // Only a strictly higher-priority redirect may replace the deferred one
                if (sel_cls > pend_cls_q) begin
                    bus.flush_id = 1'b1;
                    bus.flush_ex = sel_cls[1];
                    pend_cls_d   = sel_cls;
                    pend_tgt_d   = sel_tgt;
                end
                if (bus.imem_ack) begin
                    bus.j_br   = 1'b1;
                    bus.bta    = pend_tgt_d;
                    pend_cls_d = 2'd0;
                    pend_tgt_d = '0;
                    state_d    = RUN;
                end else begin
                    bus.stall = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        // Outputs quiesce while reset is held, whatever the inputs do
        if (reset) begin
            bus.stall        = 1'b0;
            bus.j_br         = 1'b0;
            bus.bta          = '0;
            bus.if_valid     = 1'b0;
            bus.flush_id     = 1'b0;
            bus.flush_ex     = 1'b0;
            bus.imem_timeout = 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: directed scenarios then randomized traffic.
module tb_fetch_redirect_ctrl;
    localparam int unsigned AW       = 32;
    localparam int unsigned WAIT_MAX = 15;

    typedef struct packed {
        logic          imem_req;
        logic          stall;
        logic          j_br;
        logic [AW-1:0] bta;
        logic          if_valid;
        logic          flush_id;
        logic          flush_ex;
        logic          imem_timeout;
    } obs_t;

    logic clk;
    logic reset;

    fetch_redirect_if #(.AW(AW)) bus ();

    fetch_redirect_ctrl #(.AW(AW), .WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model state: a deferred redirect is a (priority, target) pair or nothing
    bit            m_pending;
    int            m_prio;
    logic [AW-1:0] m_target;
    int            m_waited;
    bit            m_timeout;

    task automatic model_reset();
        m_pending = 0;
        m_prio    = 0;
        m_target  = '0;
        m_waited  = 0;
        m_timeout = 0;
    endtask

    task automatic model_step(input bit ack, input bit hz,
                              input bit trap, input logic [AW-1:0] tv,
                              input bit br, input logic [AW-1:0] bt,
                              input bit jmp, input logic [AW-1:0] jt,
                              output obs_t e);
        int            prio;
        logic [AW-1:0] tgt;
        prio = 0;
        tgt  = '0;
        if (jmp)  begin prio = 1; tgt = jt; end
        if (br)   begin prio = 2; tgt = bt; end
        if (trap) begin prio = 3; tgt = tv; end

        e = '0;
        e.imem_req     = 1'b1;
        e.imem_timeout = m_timeout;

        if (!m_pending) begin
            if (prio == 0) begin
                e.if_valid = ack && !hz;
                e.stall    = !e.if_valid;
            end else begin
                e.flush_id = 1'b1;
                e.flush_ex = (prio >= 2);
                if (ack) begin
                    e.j_br = 1'b1;
                    e.bta  = tgt;
                end else begin
                    e.stall   = 1'b1;
                    m_pending = 1;
                    m_prio    = prio;
                    m_target  = tgt;
                end
            end
        end else begin
            if (prio > m_prio) begin
                e.flush_id = 1'b1;
                e.flush_ex = (prio >= 2);
                m_prio     = prio;
                m_target   = tgt;
            end
            if (ack) begin
                e.j_br    = 1'b1;
                e.bta     = m_target;
                m_pending = 0;
                m_prio    = 0;
            end else begin
                e.stall = 1'b1;
            end
        end

        if (!ack && m_waited >= int'(WAIT_MAX)) m_timeout = 1;
        if (ack) m_waited = 0;
        else if (m_waited < 255) m_waited = m_waited + 1;
    endtask

    task automatic idle_inputs();
        bus.imem_ack      = 1'b0;
        bus.hazard_stall  = 1'b0;
        bus.trap_req      = 1'b0;
        bus.trap_vec      = '0;
        bus.br_taken_ex   = 1'b0;
        bus.br_target_ex  = '0;
        bus.jmp_id        = 1'b0;
        bus.jmp_target_id = '0;
    endtask

    task automatic step(input bit ack, input bit hz,
                        input bit trap, input logic [AW-1:0] tv,
                        input bit br, input logic [AW-1:0] bt,
                        input bit jmp, input logic [AW-1:0] jt);
        obs_t e;
        @(posedge clk);
        #1;
        reset             = 1'b0;
        bus.imem_ack      = ack;
        bus.hazard_stall  = hz;
        bus.trap_req      = trap;
        bus.trap_vec      = tv;
        bus.br_taken_ex   = br;
        bus.br_target_ex  = bt;
        bus.jmp_id        = jmp;
        bus.jmp_target_id = jt;
        model_step(ack, hz, trap, tv, br, bt, jmp, jt, e);
        exp_q.push_back(e);
    endtask

    task automatic rst_step();
        obs_t e;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_inputs();
        model_reset();
        e          = '0;
        e.imem_req = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle
    always @(negedge clk) begin
        obs_t a;
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.imem_req     = bus.imem_req;
            a.stall        = bus.stall;
            a.j_br         = bus.j_br;
            a.bta          = bus.bta;
            a.if_valid     = bus.if_valid;
            a.flush_id     = bus.flush_id;
            a.flush_ex     = bus.flush_ex;
            a.imem_timeout = bus.imem_timeout;
            vectors = vectors + 1;
            if (a !== e) begin
                miscompares = miscompares + 1;
                $display("FAIL vec %0d t=%0t: got req=%b stall=%b j_br=%b bta=%h ifv=%b fid=%b fex=%b to=%b, expected req=%b stall=%b j_br=%b bta=%h ifv=%b fid=%b fex=%b to=%b",
                         vectors, $time, a.imem_req, a.stall, a.j_br, a.bta, a.if_valid,
                         a.flush_id, a.flush_ex, a.imem_timeout, e.imem_req, e.stall, e.j_br,
                         e.bta, e.if_valid, e.flush_id, e.flush_ex, e.imem_timeout);
            end
        end
    end

    localparam logic [AW-1:0] Z = '0;

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();

        rst_step();
        rst_step();

        // Steady fetch with ack every cycle
        repeat (10) step(1, 0, 0, Z, 0, Z, 0, Z);
        // Hazard holds PC for two cycles, then fetch resumes
        repeat (2) step(1, 1, 0, Z, 0, Z, 0, Z);
        step(1, 0, 0, Z, 0, Z, 0, Z);
        // EX branch with ack: redirect in the same cycle
        step(1, 0, 0, Z, 1, 32'h100, 0, Z);
        step(1, 0, 0, Z, 0, Z, 0, Z);
        // ID jump without ack: deferred until the access completes
        step(0, 0, 0, Z, 0, Z, 1, 32'h40);
        repeat (2) step(0, 0, 0, Z, 0, Z, 0, Z);
        step(1, 0, 0, Z, 0, Z, 0, Z);
        step(1, 0, 0, Z, 0, Z, 0, Z);
        // Deferred jump replaced by a trap; a later branch is ignored
        step(0, 0, 0, Z, 0, Z, 1, 32'h40);
        step(0, 0, 1, 32'h80, 0, Z, 0, Z);
        step(0, 0, 0, Z, 1, 32'h123, 0, Z);
        step(0, 0, 0, Z, 0, Z, 1, 32'h55);
        step(1, 0, 0, Z, 0, Z, 0, Z);
        step(1, 0, 0, Z, 0, Z, 0, Z);
        // Replacement and ack in the same cycle
        step(0, 0, 0, Z, 0, Z, 1, 32'h200);
        step(1, 1, 0, Z, 1, 32'h300, 0, Z);
        // Long wait sets the sticky timeout; reset while pending
        repeat (int'(WAIT_MAX) + 3) step(0, 0, 0, Z, 0, Z, 0, Z);
        step(1, 0, 0, Z, 0, Z, 0, Z);
        step(0, 0, 0, Z, 0, Z, 1, 32'h44);
        rst_step();
        step(1, 0, 0, Z, 0, Z, 0, Z);
        step(1, 0, 0, Z, 0, Z, 0, Z);

        // Randomized traffic: first with frequent acks, then with slow memory
        for (int i = 0; i < 3000; i++) begin
            bit ack;
            if ($urandom_range(0, 399) == 0) begin
                rst_step();
            end else begin
                ack = (i < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
                step(ack, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 11) == 0, AW'($urandom()),
                     $urandom_range(0, 7) == 0, AW'($urandom()),
                     $urandom_range(0, 5) == 0, AW'($urandom()));
            end
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
